alu_exec_stage: RTL and testbench

- Registered execute stage wrapped around the team's combinational 32-bit ALU (AND/OR/add-subtract with 3:1 result mux).
- Accepts decoded operations over a valid/ready handshake and translates the opcode into the ALU's Operation/Binvert/Carryin controls.
- Captures the ALU output one cycle later, adds flags (zero, overflow, set-less-than) and holds the result under downstream backpressure.
- The ALU instance sits outside this block; its ports are wired to the alu_* ports below.

---
 rtl/alu_exec_stage_if.sv | 28 ++
 rtl/alu_exec_stage.sv | 148 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the upstream issue logic, the execute stage and the
// downstream consumer. The stage binds the slave side; the producer/consumer binds master.
interface alu_exec_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_overflow;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_illegal
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered execute stage around an external combinational ALU: decodes opcodes into
// ALU controls, captures the result a cycle later with flags, and holds it under backpressure.
module alu_exec_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_exec_stage_if.slave     bus,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [1:0]          alu_operation,
    output logic                alu_binvert,
    output logic                alu_carryin,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_carryout,
    output logic [COUNT_W-1:0]  op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [2:0]       op_q;
    logic             accept;
    logic             out_fire;

    logic [1:0]       dec_operation;
    logic             dec_binvert;

    logic [WIDTH-1:0] bx;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;
    logic             res_illegal;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;
    logic             illegal_q;

    assign bus.out_valid    = (state == DONE);
    assign bus.in_ready     = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_result   = result_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_illegal  = illegal_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign out_fire    = bus.out_valid && bus.out_ready;
    assign alu_carryin = alu_binvert;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = EXEC;
            EXEC:    state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = bus.in_valid ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dec_operation = 2'b00;
        dec_binvert   = 1'b0;
        case (bus.in_op)
            OP_OR:          dec_operation = 2'b01;
            OP_ADD:         dec_operation = 2'b10;
            OP_SUB, OP_SLT: begin
                dec_operation = 2'b10;
                dec_binvert   = 1'b1;
            end
            default:        dec_operation = 2'b00;
        endcase
    end

    // Overflow is judged against the operand the adder actually saw (b after inversion).
    assign bx  = alu_b ^ {WIDTH{alu_binvert}};
    assign ovf = (alu_a[WIDTH-1] == bx[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1]);

    always_comb begin
        res         = alu_result;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        case (op_q)
            OP_AND, OP_OR: ;
            OP_ADD, OP_SUB: begin
                res_carry = alu_carryout;
                res_ovf   = ovf;
            end
            OP_SLT: begin
                res       = {{(WIDTH-1){1'b0}}, alu_result[WIDTH-1] ^ ovf};
                res_carry = alu_carryout;
            end
            default: begin
                res         = '0;
                res_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            alu_binvert   <= 1'b0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            illegal_q     <= 1'b0;
            op_count      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q          <= bus.in_op;
                alu_a         <= bus.in_a;
                alu_b         <= bus.in_b;
                alu_operation <= dec_operation;
                alu_binvert   <= dec_binvert;
            end
            if (state == EXEC) begin
                result_q  <= res;
                carry_q   <= res_carry;
                zero_q    <= (res == '0);
                ovf_q     <= res_ovf;
                illegal_q <= res_illegal;
            end
            if (out_fire) begin
                op_count <= op_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push expected results, a monitor
// pops and compares on every output handshake. Includes a behavioural model of the external ALU.
module tb_alu_exec_stage;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(W)) bus ();

    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_result;
    logic [1:0]    alu_operation;
    logic          alu_binvert;
    logic          alu_carryin;
    logic          alu_carryout;
    logic [CW-1:0] op_count;

    alu_exec_stage #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_binvert   (alu_binvert),
        .alu_carryin   (alu_carryin),
        .alu_result    (alu_result),
        .alu_carryout  (alu_carryout),
        .op_count      (op_count)
    );

    // External ALU: AND / OR / add with optional b inversion and carry-in.
    logic [W-1:0] bx_m;
    logic [W:0]   sum_m;
    always_comb begin
        bx_m  = alu_b ^ {W{alu_binvert}};
        sum_m = {1'b0, alu_a} + {1'b0, bx_m} + {{W{1'b0}}, alu_carryin};
        case (alu_operation)
            2'b00:   alu_result = alu_a & bx_m;
            2'b01:   alu_result = alu_a | bx_m;
            default: alu_result = sum_m[W-1:0];
        endcase
        alu_carryout = sum_m[W];
    end

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
        logic         i;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z,
                                input logic v, input logic i);
        exp_t e;
        e.r = r; e.c = c; e.z = z; e.v = v; e.i = i;
        return e;
    endfunction

    // Monitor: a handshake occurs at the posedge following a negedge with valid & ready.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                got = {bus.out_result, bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_illegal};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h expected=none", got);
                end else begin
                    e = sb.pop_front();
                    check("result_flags", 64'(got), 64'(e));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit push);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push) sb.push_back(e);
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+3:0]  snap;
        logic [CW-1:0] cnt;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_ctl", 64'({alu_operation, alu_binvert, alu_carryin}), 64'd0);
        check("rst_out", 64'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_illegal}), 64'd0);

        // AND with latency check: EXEC after the accept edge, DONE after the next one.
        issue(3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, mk(32'h00000000, 0, 1, 0, 0), 1);
        check("lat_exec_valid", 64'(bus.out_valid), 64'd0);
        check("lat_exec_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        check("lat_done_valid", 64'(bus.out_valid), 64'd1);
        drain();

        issue(3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, mk(32'hFFFFFFFF, 0, 0, 0, 0), 1);
        drain();
        issue(3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, mk(32'hFFFFFFFF, 0, 0, 0, 0), 1);
        drain();
        issue(3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A, mk(32'h4B4B4B4B, 1, 0, 1, 0), 1);
        check("sub_ctl", 64'({alu_operation, alu_binvert, alu_carryin}), 64'({2'b10, 1'b1, 1'b1}));
        drain();
        issue(3'b111, 32'h80000000, 32'h00000001, mk(32'h00000001, 1, 0, 0, 0), 1);
        drain();
        issue(3'b111, 32'h00000005, 32'h00000005, mk(32'h00000000, 1, 1, 0, 0), 1);
        drain();
        issue(3'b011, 32'h12345678, 32'h9ABCDEF0, mk(32'h00000000, 0, 1, 0, 1), 1);
        check("ill_ctl", 64'({alu_operation, alu_binvert}), 64'd0);
        drain();
        check("count_7", 64'(op_count), 64'd7);

        // Back-to-back accepts on consecutive DONE cycles.
        issue(3'b010, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 0, 0, 1, 0), 1);
        issue(3'b110, 32'h00000003, 32'h00000003, mk(32'h00000000, 1, 1, 0, 0), 1);
        issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h00000000, 0, 1, 0, 1), 1);
        drain();
        check("count_10", 64'(op_count), 64'd10);

        // Backpressure: result must hold for 5 stalled cycles, then a same-cycle accept.
        bus.out_ready = 1'b0;
        issue(3'b001, 32'h0F0F0F0F, 32'hF0000000, mk(32'hFF0F0F0F, 0, 0, 0, 0), 1);
        @(posedge clk); #1;
        snap = {bus.out_result, bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_illegal};
        cnt  = op_count;
        check("bp_snap", 64'(snap), 64'({32'hFF0F0F0F, 4'b0000}));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_stable", 64'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_illegal}), 64'(snap));
            check("bp_in_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        end
        check("bp_count_hold", 64'(op_count), 64'(cnt));
        bus.out_ready = 1'b1;
        issue(3'b110, 32'h00000005, 32'h00000007, mk(32'hFFFFFFFE, 0, 0, 0, 0), 1);
        check("bp_count_inc", 64'(op_count), 64'(cnt + 1'b1));
        check("bp_exec", 64'(bus.out_valid), 64'd0);
        drain();

        // Reset while EXEC holds an operation: it must be dropped.
        issue(3'b010, 32'h00000001, 32'h00000001, mk(32'h0, 0, 0, 0, 0), 0);
        reset = 1'b1;
        #1;
        check("rst_exec_valid", 64'(bus.out_valid), 64'd0);
        check("rst_exec_count", 64'(op_count), 64'd0);
        check("rst_exec_alu", 64'({alu_a, alu_b}), 64'd0);
        check("rst_exec_out", 64'(bus.out_result), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("post_rst_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        end
        check("post_rst_count", 64'(op_count), 64'd0);

        // Counter wrap at 2^CW handshakes.
        for (int unsigned i = 0; i < (1 << CW) - 1; i++) begin
            issue(3'b000, W'(i), 32'hFFFFFFFF, mk(W'(i), 0, (i == 0), 0, 0), 1);
        end
        drain();
        check("count_max", 64'(op_count), 64'((1 << CW) - 1));
        issue(3'b001, 32'h0, 32'h0, mk(32'h0, 0, 1, 0, 0), 1);
        drain();
        check("count_wrap", 64'(op_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
